// File: rtl/adder_pipeline_checker.sv
// -----------------------------------------------------------------------------
// adder_pipeline_checker
//   Self-checking endpoint for a fixed-latency pipelined adder. The operands
//   driven into the adder are realigned through a LATENCY-deep delay line and
//   the adder's {c,sum} is compared against a locally computed a+b. Matches and
//   mismatches are counted (saturating), a sticky error flag is kept and the
//   first failing sample is captured for debug.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   start, stop     run control pulses
//   in_valid, a, b  operands presented to the adder this cycle
//   sum, c          adder outputs, LATENCY cycles after the operands
//   busy, done      run status (RUN/DRAIN, DONE)
//   err_flag        sticky mismatch flag for the current run
//   pass_count      matched samples (saturating)
//   err_count       mismatched samples (saturating)
//   first_err_*     operands and observed {c,sum} of the first mismatch
// -----------------------------------------------------------------------------
module adder_pipeline_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH:0]   first_err_sum
);

  localparam int DW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          clear;

  // Delay line: valid bits are reset, operand payload is not.
  logic [LATENCY-1:0]            dl_v_q, dl_v_d;
  logic [LATENCY-1:0][WIDTH-1:0] dl_a_q, dl_a_d;
  logic [LATENCY-1:0][WIDTH-1:0] dl_b_q, dl_b_d;

  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] fe_a_q, fe_a_d;
  logic [WIDTH-1:0] fe_b_q, fe_b_d;
  logic [WIDTH:0]   fe_sum_q, fe_sum_d;

  logic             cmp_en;
  logic [WIDTH-1:0] tail_a, tail_b;
  logic [WIDTH:0]   expected, observed;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        // stop has priority; start is meaningless while running.
        if (stop) begin
          state_d = DRAIN;
          drain_d = DW'(LATENCY);
        end
      end
      DRAIN: begin
        // The last accepted operand reaches the tail on the edge the
        // counter hits zero, so the final compare lands on DRAIN->DONE.
        drain_d = drain_q - DW'(1);
        if (drain_q == DW'(1)) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand delay line, realigning a/b with the adder output
  // ---------------------------------------------------------------------------
  always_comb begin
    dl_v_d    = '0;
    dl_a_d    = dl_a_q;
    dl_b_d    = dl_b_q;
    dl_v_d[0] = in_valid && (state_q == RUN);
    dl_a_d[0] = a;
    dl_b_d[0] = b;
    for (int i = 1; i < LATENCY; i++) begin
      dl_v_d[i] = dl_v_q[i-1];
      dl_a_d[i] = dl_a_q[i-1];
      dl_b_d[i] = dl_b_q[i-1];
    end
    if (clear) dl_v_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Compare and statistics
  // ---------------------------------------------------------------------------
  assign tail_a   = dl_a_q[LATENCY-1];
  assign tail_b   = dl_b_q[LATENCY-1];
  assign expected = {1'b0, tail_a} + {1'b0, tail_b};
  assign observed = {c, sum};
  assign cmp_en   = dl_v_q[LATENCY-1] && ((state_q == RUN) || (state_q == DRAIN));

  always_comb begin
    pass_d     = pass_q;
    err_d      = err_q;
    err_flag_d = err_flag_q;
    fe_a_d     = fe_a_q;
    fe_b_d     = fe_b_q;
    fe_sum_d   = fe_sum_q;
    if (clear) begin
      pass_d     = '0;
      err_d      = '0;
      err_flag_d = 1'b0;
      fe_a_d     = '0;
      fe_b_d     = '0;
      fe_sum_d   = '0;
    end else if (cmp_en) begin
      if (observed == expected) begin
        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
      end else begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        err_flag_d = 1'b1;
        // err_count saturates and never wraps to zero, so this fires once.
        if (err_q == '0) begin
          fe_a_d   = tail_a;
          fe_b_d   = tail_b;
          fe_sum_d = observed;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its _d value from before the edge, independent of order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      dl_v_q     <= '0;
      err_flag_q <= 1'b0;
      pass_q     <= '0;
      err_q      <= '0;
      fe_a_q     <= '0;
      fe_b_q     <= '0;
      fe_sum_q   <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      dl_v_q     <= dl_v_d;
      err_flag_q <= err_flag_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fe_a_q     <= fe_a_d;
      fe_b_q     <= fe_b_d;
      fe_sum_q   <= fe_sum_d;
    end
  end

  // NOTE: the operand payload is deliberately left without reset; it is only
  // ever looked at when its valid bit is set, and the valids are reset.
  always_ff @(posedge CLK) begin
    dl_a_q <= dl_a_d;
    dl_b_q <= dl_b_d;
  end

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign err_flag      = err_flag_q;
  assign pass_count    = pass_q;
  assign err_count     = err_q;
  assign first_err_a   = fe_a_q;
  assign first_err_b   = fe_b_q;
  assign first_err_sum = fe_sum_q;

endmodule

// File: tb/tb_adder_pipeline_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_pipeline_checker
//   Directed bench for adder_pipeline_checker. A behavioural 2-stage adder sits
//   in front of the checker and can return a forced {c,sum} for chosen
//   operands. A second checker instance with CNT_W=2 shares all inputs and is
//   used for the counter-saturation case.
// -----------------------------------------------------------------------------
module tb_adder_pipeline_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [3:0] sum;
  logic       c;
  logic       inj = 1'b0;
  logic [4:0] inj_val = '0;

  logic        busy, done, err_flag;
  logic [15:0] pass_count, err_count;
  logic [3:0]  first_err_a, first_err_b;
  logic [4:0]  first_err_sum;

  logic        s_busy, s_done, s_err_flag;
  logic [1:0]  s_pass_count, s_err_count;
  logic [3:0]  s_first_err_a, s_first_err_b;
  logic [4:0]  s_first_err_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  // Behavioural adder: two register stages, optional forced result.
  logic [3:0] p1_a = '0, p1_b = '0, p2_a = '0, p2_b = '0;
  logic       p1_inj = 1'b0, p2_inj = 1'b0;
  logic [4:0] p1_iv = '0, p2_iv = '0;

  always @(posedge CLK) begin
    p1_a <= a;    p1_b <= b;    p1_inj <= inj;    p1_iv <= inj_val;
    p2_a <= p1_a; p2_b <= p1_b; p2_inj <= p1_inj; p2_iv <= p1_iv;
  end

  assign {c, sum} = p2_inj ? p2_iv : ({1'b0, p2_a} + {1'b0, p2_b});

  adder_pipeline_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .sum(sum), .c(c),
    .busy(busy), .done(done), .err_flag(err_flag),
    .pass_count(pass_count), .err_count(err_count),
    .first_err_a(first_err_a), .first_err_b(first_err_b),
    .first_err_sum(first_err_sum)
  );

  adder_pipeline_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(2)) dut_small (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .in_valid(in_valid),
    .a(a), .b(b), .sum(sum), .c(c),
    .busy(s_busy), .done(s_done), .err_flag(s_err_flag),
    .pass_count(s_pass_count), .err_count(s_err_count),
    .first_err_a(s_first_err_a), .first_err_b(s_first_err_b),
    .first_err_sum(s_first_err_sum)
  );

  // Inputs change on the falling edge and are sampled by the next rising edge.
  task automatic drive(input logic st, input logic sp, input logic v,
                       input logic [3:0] aa, input logic [3:0] bb,
                       input logic fi, input logic [4:0] fv);
    @(negedge CLK);
    start = st; stop = sp; in_valid = v; a = aa; b = bb; inj = fi; inj_val = fv;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, err_flag, pass_count, err_count, first_err_a, first_err_b, first_err_sum} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%0b done=%0b flag=%0b pass=%0d err=%0d fa=%h fb=%h fs=%h, required all 0",
               busy, done, err_flag, pass_count, err_count, first_err_a, first_err_b, first_err_sum);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    idle();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_clean_run();
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    for (int i = 0; i < 16; i++)
      drive(1'b0, i == 15, 1'b1, 4'(i), 4'(15 - i), 1'b0, 5'h00);
    idle();
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL clean_drain1: busy=%0b done=%0b, required 1 0", busy, done);
    end
    idle();
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL clean_drain2: busy=%0b done=%0b, required 1 0", busy, done);
    end
    idle();
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL clean_done: busy=%0b done=%0b, required 0 1", busy, done);
    end
    n_cmp++;
    if (pass_count !== 16'd16 || err_count !== 16'd0 || err_flag !== 1'b0) begin
      n_err++;
      $display("FAIL clean_counts: pass=%0d err=%0d flag=%0b, required 16 0 0", pass_count, err_count, err_flag);
    end
    n_cmp++;
    if (s_pass_count !== 2'd3) begin
      n_err++;
      $display("FAIL clean_pass_sat: pass=%0d, required 3", s_pass_count);
    end
  endtask

  task automatic test_carry();
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    drive(1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 5'h00);
    drive(1'b0, 1'b1, 1'b1, 4'h8, 4'h8, 1'b0, 5'h00);
    repeat (3) idle();
    n_cmp++;
    if (done !== 1'b1 || pass_count !== 16'd2 || err_count !== 16'd0) begin
      n_err++;
      $display("FAIL carry_counts: done=%0b pass=%0d err=%0d, required 1 2 0", done, pass_count, err_count);
    end
  endtask

  task automatic test_fault();
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    drive(1'b0, 1'b0, 1'b1, 4'h3, 4'h5, 1'b1, 5'h09);
    drive(1'b0, 1'b0, 1'b1, 4'h2, 4'h2, 1'b0, 5'h00);
    drive(1'b0, 1'b0, 1'b1, 4'h1, 4'h1, 1'b1, 5'h05);
    drive(1'b0, 1'b1, 1'b1, 4'h4, 4'h4, 1'b0, 5'h00);
    repeat (3) idle();
    n_cmp++;
    if (done !== 1'b1 || pass_count !== 16'd2 || err_count !== 16'd2 || err_flag !== 1'b1) begin
      n_err++;
      $display("FAIL fault_counts: done=%0b pass=%0d err=%0d flag=%0b, required 1 2 2 1",
               done, pass_count, err_count, err_flag);
    end
    n_cmp++;
    if (first_err_a !== 4'h3 || first_err_b !== 4'h5 || first_err_sum !== 5'h09) begin
      n_err++;
      $display("FAIL fault_capture: a=%h b=%h sum=%h, required 3 5 09", first_err_a, first_err_b, first_err_sum);
    end
  endtask

  task automatic test_reset_mid_run();
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    drive(1'b0, 1'b0, 1'b1, 4'h1, 4'h2, 1'b0, 5'h00);
    drive(1'b0, 1'b0, 1'b1, 4'h3, 4'h4, 1'b0, 5'h00);
    idle();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_busy: busy=%0b, required 1", busy);
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, err_flag, pass_count, err_count} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: busy=%0b done=%0b flag=%0b pass=%0d err=%0d, required all 0",
               busy, done, err_flag, pass_count, err_count);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    drive(1'b0, 1'b1, 1'b1, 4'h6, 4'h7, 1'b0, 5'h00);
    repeat (3) idle();
    n_cmp++;
    if (done !== 1'b1 || pass_count !== 16'd1 || err_count !== 16'd0) begin
      n_err++;
      $display("FAIL midrun_rerun: done=%0b pass=%0d err=%0d, required 1 1 0", done, pass_count, err_count);
    end
  endtask

  task automatic test_control();
    // start in DONE clears the previous run's counts
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    idle();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || pass_count !== 16'd0) begin
      n_err++;
      $display("FAIL ctrl_restart: busy=%0b done=%0b pass=%0d, required 1 0 0", busy, done, pass_count);
    end
    // start+stop together: stop wins, operand on that cycle accepted
    drive(1'b1, 1'b1, 1'b1, 4'h2, 4'h3, 1'b0, 5'h00);
    // start while draining must be ignored
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL ctrl_start_stop: busy=%0b done=%0b, required 1 0", busy, done);
    end
    idle();
    idle();
    n_cmp++;
    if (done !== 1'b1 || pass_count !== 16'd1) begin
      n_err++;
      $display("FAIL ctrl_drain_start: done=%0b pass=%0d, required 1 1", done, pass_count);
    end
    // stop in IDLE is ignored
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    idle();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL ctrl_idle_stop: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 5'h00);
    for (int i = 0; i < 5; i++)
      drive(1'b0, i == 4, 1'b1, 4'(i + 1), 4'h0, 1'b1, 5'h1F);
    repeat (3) idle();
    n_cmp++;
    if (done !== 1'b1 || err_count !== 16'd5 || pass_count !== 16'd0) begin
      n_err++;
      $display("FAIL sat_wide: done=%0b err=%0d pass=%0d, required 1 5 0", done, err_count, pass_count);
    end
    n_cmp++;
    if (s_err_count !== 2'd3 || s_err_flag !== 1'b1) begin
      n_err++;
      $display("FAIL sat_narrow: err=%0d flag=%0b, required 3 1", s_err_count, s_err_flag);
    end
    n_cmp++;
    if (s_first_err_a !== 4'h1 || s_first_err_b !== 4'h0 || s_first_err_sum !== 5'h1F) begin
      n_err++;
      $display("FAIL sat_capture: a=%h b=%h sum=%h, required 1 0 1f", s_first_err_a, s_first_err_b, s_first_err_sum);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_carry();
    test_fault();
    test_reset();
    test_reset_mid_run();
    test_control();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion within 100000 time units");
    $fatal(1);
  end

endmodule
